boot_loader_ctrl: RTL
=====================

// Module: boot_loader_ctrl
// PURPOSE
//  Sequences CPU bring-up. Holds risc_v_cpu in reset and streams a byte image
//  (program binary) into instruction memory as 32-bit little-endian words.
//  Then releases the CPU after a fixed hold time. Sits between the host/byte
//  source and the instruction memory write port plus the CPU reset input.
// PARAMETERS
//  ADDR_WIDTH  32    width of imem_addr (byte address)
//  MEM_WORDS   1024  instruction memory capacity in 32-bit words
//  BASE_ADDR   0     byte address of first word written
//  RESET_HOLD  4     cycles cpu_reset stays high after the final write (>=1)
// PORTS
//  clock       in   1           system clock
//  reset       in   1           synchronous, active-high
//  start       in   1           1-cycle pulse: begin image load
//  byte_valid  in   1           byte source has data
//  byte_data   in   8           image byte
//  byte_last   in   1           qualifies final byte of image
//  byte_ready  out  1           controller accepts byte this cycle
//  imem_we     out  1           instruction memory write strobe
//  imem_addr   out  ADDR_WIDTH  byte address of word write
//  imem_wdata  out  32          word to write
//  cpu_reset   out  1           reset to CPU core (active-high)
//  busy        out  1           LOAD or HOLD in progress
//  done        out  1           CPU running with loaded image
//  error       out  1           image overflow / checksum failure (sticky)
//  exp_sum     in   32          expected checksum (BOOT_CHECKSUM_EN only)
// BEHAVIOUR
//  Reset values: byte_ready=0 imem_we=0 imem_addr=BASE_ADDR imem_wdata=0
//   cpu_reset=1 busy=0 done=0 error=0; state IDLE; byte lane 0; word count 0.
//  States: IDLE -> LOAD -> HOLD -> RUN; ERROR terminal until reset.
//  IDLE: byte_ready=0. start -> LOAD next cycle, lane=0, count=0.
//  LOAD: byte_ready=1. Byte accepted on byte_valid&byte_ready; lane k fills
//   bits [8k+7:8k]; first byte -> [7:0]. byte_valid gaps allowed, no timeout.
//  Word write: lane-3 byte or byte_last accepted at edge N -> imem_we=1 in
//   cycle N+1, imem_addr=BASE_ADDR+4*count, then count++. Partial final word
//   has unfilled lanes = 0x00. imem_we is a single-cycle pulse per word.
//  byte_last -> HOLD starting with the cycle after final imem_we.
//  byte_last with lane 0 and no byte -> n/a; every last byte is a real byte.
//  Overflow: byte accepted while count==MEM_WORDS -> ERROR next cycle, no
//   write issued; error=1, byte_ready=0, cpu_reset=1 held.
//  HOLD: counts RESET_HOLD cycles, byte_ready=0, cpu_reset=1, busy=1.
//  RUN: cpu_reset=0, done=1, busy=0. Final write in cycle W -> HOLD occupies
//   W+1..W+RESET_HOLD, cpu_reset=0/done=1 from W+RESET_HOLD+1.
//  start in RUN: cpu_reset=1, done=0 next cycle; enter LOAD, addr=BASE_ADDR.
//  start in LOAD/HOLD/ERROR ignored.
//  reset mid-operation: all outputs to reset values at that edge; partial
//   word discarded, no imem_we issued.
//  count width = clog2(MEM_WORDS+1); addr arithmetic modulo 2^ADDR_WIDTH.
// CONFIGURATION
//  BOOT_CHECKSUM_EN defined: exp_sum port present; 32-bit sum (mod 2^32) of
//   all written words. At end of LOAD, sum!=exp_sum -> ERROR instead of HOLD.
//   sum cleared on start.
//  BOOT_CHECKSUM_EN undefined: no exp_sum port, no sum logic; LOAD -> HOLD.
// TESTING
//  8 bytes 13 05 10 00 93 05 20 00 (last on 8th), RESET_HOLD=4 -> writes
//   0x00100513@0, 0x00200593@4; cpu_reset falls exactly 5 cycles after 2nd we.
//  6 bytes 13 05 10 00 93 05 (last on 6th) -> 2nd write 0x00000593@4.
//  Same 8 bytes with byte_valid low every other cycle -> identical writes.
//   Address/timing relative to final write unchanged.
//  MEM_WORDS=4, 17 bytes -> exactly 4 writes, error=1 after 17th byte.
//   cpu_reset stays 1, done=0.
//  reset high after 3 bytes accepted -> no imem_we, outputs at reset values.
//   Restart loads word 0 at BASE_ADDR.
//  BOOT_CHECKSUM_EN, image above, exp_sum=0x00300AA6 -> RUN.
//   exp_sum=0 -> error=1, cpu_reset=1.

Source files
------------

// File: rtl/boot_loader_ctrl_if.sv
// Byte-stream input and instruction-memory write port of the boot loader.
// The slave modport is the controller's view; the master modport drives bytes and watches writes.
interface boot_loader_ctrl_if #(
  parameter int ADDR_WIDTH = 32
);
  logic                  byte_valid;
  logic [7:0]            byte_data;
  logic                  byte_last;
  logic                  byte_ready;
  logic                  imem_we;
  logic [ADDR_WIDTH-1:0] imem_addr;
  logic [31:0]           imem_wdata;

  modport master (
    output byte_valid, byte_data, byte_last,
    input  byte_ready, imem_we, imem_addr, imem_wdata
  );

  modport slave (
    input  byte_valid, byte_data, byte_last,
    output byte_ready, imem_we, imem_addr, imem_wdata
  );
endinterface

// File: rtl/boot_loader_ctrl.sv
// CPU bring-up sequencer: packs image bytes into LE words (write one cycle after the 4th/last byte),
// holds cpu_reset for RESET_HOLD cycles after the final write, then releases it. Macro: BOOT_CHECKSUM_EN.
module boot_loader_ctrl #(
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    MEM_WORDS  = 1024,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0,
  parameter int                    RESET_HOLD = 4
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               start,
  boot_loader_ctrl_if.slave  bus,
  output logic               cpu_reset,
  output logic               busy,
  output logic               done,
  output logic               error
`ifdef BOOT_CHECKSUM_EN
  ,
  input  logic [31:0]        exp_sum
`endif
);

  localparam int CW = $clog2(MEM_WORDS + 1);
  localparam int HW = (RESET_HOLD > 1) ? $clog2(RESET_HOLD) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_LAST,
    S_HOLD,
    S_RUN,
    S_ERROR
  } state_t;

  state_t          state;
  logic [1:0]      lane;
  logic [CW-1:0]   count;
  logic [31:0]     word_buf;
  logic [HW-1:0]   hold_cnt;
`ifdef BOOT_CHECKSUM_EN
  logic [31:0]     sum;
`endif

  logic                  accept;
  logic                  full;
  logic [31:0]           word_next;
  logic [ADDR_WIDTH-1:0] word_addr;

  assign accept    = bus.byte_valid & bus.byte_ready;
  assign full      = (count == CW'(MEM_WORDS));
  // word_buf is cleared after every write, so lanes not yet filled read as zero
  assign word_next = word_buf | ({24'd0, bus.byte_data} << {lane, 3'b000});
  assign word_addr = BASE_ADDR + (ADDR_WIDTH'(count) << 2);

  always_ff @(posedge clock) begin
    if (reset) begin
      state          <= S_IDLE;
      lane           <= 2'd0;
      count          <= '0;
      word_buf       <= '0;
      hold_cnt       <= '0;
      bus.byte_ready <= 1'b0;
      bus.imem_we    <= 1'b0;
      bus.imem_addr  <= BASE_ADDR;
      bus.imem_wdata <= '0;
      cpu_reset      <= 1'b1;
      busy           <= 1'b0;
      done           <= 1'b0;
      error          <= 1'b0;
`ifdef BOOT_CHECKSUM_EN
      sum            <= '0;
`endif
    end else begin
      bus.imem_we <= 1'b0;
      case (state)
        S_IDLE, S_RUN: begin
          if (start) begin
            state          <= S_LOAD;
            lane           <= 2'd0;
            count          <= '0;
            word_buf       <= '0;
            bus.byte_ready <= 1'b1;
            bus.imem_addr  <= BASE_ADDR;
            cpu_reset      <= 1'b1;
            busy           <= 1'b1;
            done           <= 1'b0;
`ifdef BOOT_CHECKSUM_EN
            sum            <= '0;
`endif
          end
        end

        S_LOAD: begin
          if (accept) begin
            if (full) begin
              // memory already holds MEM_WORDS words: no write, lock up
              state          <= S_ERROR;
              bus.byte_ready <= 1'b0;
              busy           <= 1'b0;
              error          <= 1'b1;
            end else if (lane == 2'd3 || bus.byte_last) begin
              bus.imem_we    <= 1'b1;
              bus.imem_addr  <= word_addr;
              bus.imem_wdata <= word_next;
              count          <= count + CW'(1);
              lane           <= 2'd0;
              word_buf       <= '0;
`ifdef BOOT_CHECKSUM_EN
              sum            <= sum + word_next;
`endif
              if (bus.byte_last) begin
                state          <= S_LAST;
                bus.byte_ready <= 1'b0;
              end
            end else begin
              word_buf <= word_next;
              lane     <= lane + 2'd1;
            end
          end
        end

        // final write strobe is on the bus this cycle
        S_LAST: begin
`ifdef BOOT_CHECKSUM_EN
          if (sum != exp_sum) begin
            state <= S_ERROR;
            busy  <= 1'b0;
            error <= 1'b1;
          end else begin
            state    <= S_HOLD;
            hold_cnt <= '0;
          end
`else
          state    <= S_HOLD;
          hold_cnt <= '0;
`endif
        end

        S_HOLD: begin
          if (hold_cnt == HW'(RESET_HOLD - 1)) begin
            state     <= S_RUN;
            cpu_reset <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b1;
          end else begin
            hold_cnt <= hold_cnt + HW'(1);
          end
        end

        S_ERROR: begin
          state <= S_ERROR;
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
